// File: rtl/bus_pkg.sv
// Shared types and constants for the 256-bit peripheral bus and its DMA master.
package bus_pkg;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned ADDR_W = 16;

  // Peripheral select that no device decodes; parks the bus between beats.
  localparam logic [3:0] IDLE_PERIPH = 4'hF;
  localparam logic [3:0] RAM_PERIPH  = 4'h0;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    TURN,
    WR,
    DONE
  } dma_state_t;

  typedef struct packed {
    logic [3:0]  periph;
    logic [11:0] offset;
  } bus_addr_t;

  localparam bus_addr_t IDLE_ADDR = '{periph: IDLE_PERIPH, offset: 12'h000};

  // Next word address; the offset wraps inside the same peripheral.
  function automatic bus_addr_t addr_inc(bus_addr_t a);
    bus_addr_t r;
    r.periph = a.periph;
    r.offset = a.offset + 12'd1;
    return r;
  endfunction

endpackage

// File: rtl/bus_dma_master_if.sv
// Address and strobe group of the shared peripheral bus.
interface bus_dma_master_if;
  import bus_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              nRead;
  logic              nWrite;

  modport master (
    output addr,
    output nRead,
    output nWrite
  );

  modport slave (
    input addr,
    input nRead,
    input nWrite
  );

endinterface

// File: rtl/bus_tristate_port.sv
// Word buffer plus registered output enable for the shared data bus.
module bus_tristate_port
  import bus_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,   // capture bus_io at the next edge
  input  logic              drive_i,  // drive the buffer during the next cycle
  inout  wire  [DATA_W-1:0] bus_io
);

  logic [DATA_W-1:0] data_q;
  logic              oe_q;

  // Buffer capture and output-enable register; reset releases the bus at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      oe_q <= drive_i;
      if (load_i) begin
        data_q <= bus_io;
      end
    end
  end

  assign bus_io = oe_q ? data_q : {DATA_W{1'bz}};

endmodule

// File: rtl/bus_dma_master.sv
// Block-copy bus initiator: read word, turnaround, write word, three cycles per word.
module bus_dma_master
  import bus_pkg::*;
(
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        src_addr,
  input  logic [ADDR_W-1:0]        dst_addr,
  input  logic [11:0]              len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  bus_dma_master_if.master         dma_bus,
  inout  wire  [DATA_W-1:0]        bus
);

  dma_state_t state_q, state_d;
  bus_addr_t  src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [11:0] cnt_q, cnt_d;
  logic nread_q, nread_d, nwrite_q, nwrite_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic load, drive;

  bus_addr_t src_in, dst_in;
  assign src_in = bus_addr_t'(src_addr);
  assign dst_in = bus_addr_t'(dst_addr);

  // Next state and next registered outputs; every output is idle unless a beat needs it.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    addr_d   = IDLE_ADDR;
    nread_d  = 1'b1;
    nwrite_d = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    load     = 1'b0;
    drive    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (src_in.periph == IDLE_PERIPH || dst_in.periph == IDLE_PERIPH) begin
            err_d = 1'b1;
          end else if (len == 12'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            src_d   = src_in;
            dst_d   = dst_in;
            cnt_d   = len;
            state_d = RD;
            addr_d  = src_in;
            nread_d = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      RD: begin
        load    = 1'b1;
        state_d = TURN;
        busy_d  = 1'b1;
      end
      TURN: begin
        state_d  = WR;
        addr_d   = dst_q;
        nwrite_d = 1'b0;
        drive    = 1'b1;
        busy_d   = 1'b1;
      end
      WR: begin
        src_d = addr_inc(src_q);
        dst_d = addr_inc(dst_q);
        cnt_d = cnt_q - 12'd1;
        if (cnt_q != 12'd1) begin
          state_d = RD;
          addr_d  = src_d;
          nread_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and output registers; reset parks the bus immediately.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      src_q    <= IDLE_ADDR;
      dst_q    <= IDLE_ADDR;
      cnt_q    <= 12'd0;
      addr_q   <= IDLE_ADDR;
      nread_q  <= 1'b1;
      nwrite_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      nread_q  <= nread_d;
      nwrite_q <= nwrite_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  bus_tristate_port u_port (
    .clk_i   (clk),
    .rst_ni  (nReset),
    .load_i  (load),
    .drive_i (drive),
    .bus_io  (bus)
  );

  assign dma_bus.addr   = addr_q;
  assign dma_bus.nRead  = nread_q;
  assign dma_bus.nWrite = nwrite_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: memory responder, timeline model, directed copy scenarios.
module tb_bus_dma_master;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [11:0] len = '0;
  logic busy, done, err;
  wire  [DATA_W-1:0] bus;

  logic rsp_oe = 1'b0;
  logic [DATA_W-1:0] rsp_data = '0;
  assign bus = rsp_oe ? rsp_data : {DATA_W{1'bz}};

  bus_dma_master_if dma_bus ();

  bus_dma_master dut (
    .clk      (clk),
    .nReset   (nReset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dma_bus  (dma_bus),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int p, input int o);
    logic [DATA_W-1:0] w;
    for (int j = 0; j < 16; j++) w[j*16 +: 16] = 16'(p * 4099 + o * 31 + j * 7 + 1);
    return w;
  endfunction

  // Peripherals 0 and 1 are memories; mem is the responder, ref_mem the model's copy.
  logic [DATA_W-1:0] mem     [2][4096];
  logic [DATA_W-1:0] ref_mem [2][4096];
  int init_seq = 0;
  int init_done = -1;
  int init_mode = 0;

  // Model: timeline of a transfer counted in edges since the accepting edge E0.
  bit m_act = 1'b0;
  int m_k = 0;
  int m_len = 0;
  logic [15:0] m_src = '0, m_dst = '0;
  logic [15:0] exp_addr = 16'hF000;
  logic exp_nr = 1'b1, exp_nw = 1'b1, exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic [DATA_W-1:0] m_buf = '0;

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_act = 1'b0;
      exp_addr = 16'hF000;
      exp_nr = 1'b1; exp_nw = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    end else begin
      exp_err = 1'b0;
      if (m_act) begin
        m_k = m_k + 1;
        if (m_k > 3 * m_len) m_act = 1'b0;
      end else if (start) begin
        if (src_addr[15:12] == IDLE_PERIPH || dst_addr[15:12] == IDLE_PERIPH) begin
          exp_err = 1'b1;
        end else begin
          m_act = 1'b1; m_k = 0; m_len = int'(len); m_src = src_addr; m_dst = dst_addr;
        end
      end
      exp_addr = 16'hF000;
      exp_nr = 1'b1; exp_nw = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      if (m_act) begin
        if (m_k < 3 * m_len) begin
          exp_busy = 1'b1;
          if (m_k % 3 == 0) begin
            exp_addr = {m_src[15:12], 12'(int'(m_src[11:0]) + m_k / 3)};
            exp_nr = 1'b0;
          end else if (m_k % 3 == 2) begin
            exp_addr = {m_dst[15:12], 12'(int'(m_dst[11:0]) + m_k / 3)};
            exp_nw = 1'b0;
          end
        end else begin
          exp_done = 1'b1;
        end
      end
    end
  end

  // Negedge: memory init requests, per-cycle compare, then the responder beat.
  always @(negedge clk) begin
    if (init_seq != init_done) begin
      for (int p = 0; p < 2; p++)
        for (int o = 0; o < 4096; o++) begin
          mem[p][o] = init_word(p, o);
          ref_mem[p][o] = init_word(p, o);
        end
      if (init_mode == 1) begin
        mem[0][10] = 256'h9;
        ref_mem[0][10] = 256'h9;
      end
      init_done = init_seq;
    end
    if (nReset) begin
      chk("addr", DATA_W'(dma_bus.addr), DATA_W'(exp_addr));
      chk("nRead", DATA_W'(dma_bus.nRead), DATA_W'(exp_nr));
      chk("nWrite", DATA_W'(dma_bus.nWrite), DATA_W'(exp_nw));
      chk("busy", DATA_W'(busy), DATA_W'(exp_busy));
      chk("done", DATA_W'(done), DATA_W'(exp_done));
      chk("err", DATA_W'(err), DATA_W'(exp_err));
      if (!exp_nr) m_buf = ref_mem[exp_addr[12]][exp_addr[11:0]];
      if (!exp_nw) begin
        chk("bus_wr_data", bus, m_buf);
        ref_mem[exp_addr[12]][exp_addr[11:0]] = m_buf;
      end
    end
    rsp_oe = 1'b0;
    if (!dma_bus.nRead && dma_bus.addr[15:13] == 3'b000) begin
      rsp_oe = 1'b1;
      rsp_data = mem[dma_bus.addr[12]][dma_bus.addr[11:0]];
    end
    if (!dma_bus.nWrite && dma_bus.addr[15:13] == 3'b000)
      mem[dma_bus.addr[12]][dma_bus.addr[11:0]] = bus;
  end

  task automatic load_mem(input int mode);
    init_mode = mode;
    init_seq++;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [11:0] n);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Bit k of each mask records the signal in the cycle after edge E(k).
  int done_m, nr_m, nw_m, busy_m, err_m, addr_bad;
  task automatic observe(input int n);
    done_m = 0; nr_m = 0; nw_m = 0; busy_m = 0; err_m = 0; addr_bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) done_m |= (1 << k);
      if (!dma_bus.nRead) nr_m |= (1 << k);
      if (!dma_bus.nWrite) nw_m |= (1 << k);
      if (busy) busy_m |= (1 << k);
      if (err) err_m |= (1 << k);
      if (dma_bus.addr != 16'hF000) addr_bad++;
    end
  endtask

  logic released;

  initial begin
    load_mem(0);
    #2;
    chk("rst_addr", DATA_W'(dma_bus.addr), DATA_W'(16'hF000));
    chk("rst_strobes", DATA_W'({dma_bus.nRead, dma_bus.nWrite}), DATA_W'(2'b11));
    chk("rst_flags", DATA_W'({busy, done, err}), DATA_W'(3'b000));
    @(negedge clk);
    nReset = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word copy 0x0000 -> 0x0002.
    do_start(16'h0000, 16'h0002, 12'd2);
    observe(10);
    chk("t1_done_mask", DATA_W'(done_m), DATA_W'(32'h40));
    chk("t1_nread_mask", DATA_W'(nr_m), DATA_W'(32'h09));
    chk("t1_nwrite_mask", DATA_W'(nw_m), DATA_W'(32'h24));
    chk("t1_busy_mask", DATA_W'(busy_m), DATA_W'(32'h3F));
    chk("t1_mem2", mem[0][2], init_word(0, 0));
    chk("t1_mem3", mem[0][3], init_word(0, 1));

    // Overlapping forward copy propagates the first word.
    load_mem(1);
    do_start(16'h000A, 16'h000B, 12'd2);
    observe(8);
    chk("t2_mem11", mem[0][11], 256'h9);
    chk("t2_mem12", mem[0][12], 256'h9);

    // Zero length: done only, bus parked.
    do_start(16'h0000, 16'h0005, 12'd0);
    observe(4);
    chk("t3_done_mask", DATA_W'(done_m), DATA_W'(32'h1));
    chk("t3_strobes", DATA_W'(nr_m | nw_m | busy_m), DATA_W'(0));
    chk("t3_addr_moves", DATA_W'(addr_bad), DATA_W'(0));

    // Destination in the undecoded peripheral is rejected.
    do_start(16'h0000, 16'hF004, 12'd3);
    observe(4);
    chk("t4_err_mask", DATA_W'(err_m), DATA_W'(32'h1));
    chk("t4_quiet", DATA_W'(nr_m | nw_m | busy_m | done_m), DATA_W'(0));

    // Offset wrap on both sides, across peripherals.
    load_mem(0);
    do_start(16'h0FFE, 16'h1FFF, 12'd3);
    observe(11);
    chk("t5_done_mask", DATA_W'(done_m), DATA_W'(32'h200));
    chk("t5_dst_fff", mem[1][12'hFFF], init_word(0, 12'hFFE));
    chk("t5_dst_000", mem[1][0], init_word(0, 12'hFFF));
    chk("t5_dst_001", mem[1][1], init_word(0, 0));

    // Start while busy is ignored.
    load_mem(0);
    do_start(16'h0000, 16'h0020, 12'd2);
    do_start(16'h0005, 16'h0030, 12'd1);
    observe(8);
    chk("t6_no_err", DATA_W'(err_m), DATA_W'(0));
    chk("t6_mem20", mem[0][32'h20], init_word(0, 0));
    chk("t6_mem21", mem[0][32'h21], init_word(0, 1));
    chk("t6_mem30", mem[0][32'h30], init_word(0, 32'h30));

    // Reset during the second write beat.
    load_mem(0);
    do_start(16'h0000, 16'h0002, 12'd2);
    repeat (5) @(posedge clk);
    #2 nReset = 1'b0;
    #1;
    released = (bus === {DATA_W{1'b0}}) || (bus === {DATA_W{1'bz}});
    chk("t7_addr", DATA_W'(dma_bus.addr), DATA_W'(16'hF000));
    chk("t7_nwrite", DATA_W'(dma_bus.nWrite), DATA_W'(1'b1));
    chk("t7_bus_released", DATA_W'(released), DATA_W'(1'b1));
    chk("t7_busy", DATA_W'(busy), DATA_W'(1'b0));
    repeat (2) @(negedge clk);
    #2 nReset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_mem2", mem[0][2], init_word(0, 0));
    chk("t7_mem3", mem[0][3], init_word(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
